multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, the number of consecutive wait cycles without mem_ready before a memory timeout (legal range 2..255).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: ports clk (input, 1) and rst_n (input, 1).
REQ-003 SHALL have the following inputs:
- opcode, input, 7, instruction opcode from IR.
- zero, input, 1, ALU zero flag.
- mem_ready, input, 1, memory transfer completes this cycle.
REQ-004 SHALL have the following outputs:
- mem_req, output, 1, memory access request.
- mem_write, output, 1, request is a write.
- adr_src, output, 1, address select: 0 = PC, 1 = ALUOut.
- ir_write, output, 1, load IR and OldPC.
- pc_write, output, 1, load PC.
- reg_write, output, 1, register-file write.
REQ-005 SHALL have the following outputs:
- alu_src_a, output, 2, A-operand select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b, output, 2, B-operand select: 00 = rs2, 01 = imm, 10 = constant 4.
- alu_op, output, 2, ALU operation class: 00 = add, 01 = sub/compare, 10 = funct decode.
- result_src, output, 2, result select: 00 = ALUOut, 01 = read data, 10 = ALU result.
- imm_src, output, 2, immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- illegal_instr, output, 1, one-cycle pulse on an illegal opcode.
- mem_timeout, output, 1, one-cycle pulse on a memory timeout.

Function
REQ-006 SHALL implement the states IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, JALR_PC, JALR_LINK and FAULT; every output SHALL be 0 unless this document specifies otherwise for the current state.
REQ-007 SHALL drive outputs per state as follows:
- IDLE: all outputs 0.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=1 and pc_write=1 only in the cycle mem_ready=1.
- DECODE: a=01, b=01, alu_op=00 (computes the branch/JAL target).
REQ-008 SHALL drive memory-phase outputs as follows:
- MEMADR: a=10, b=01, alu_op=00.
- MEMREAD: mem_req=1, adr_src=1.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1.
- MEMWB: result_src=01, reg_write=1.
REQ-009 SHALL drive execute-phase outputs as follows:
- EXECR: a=10, b=00, alu_op=10.
- EXECI: a=10, b=01, alu_op=10.
- ALUWB: result_src=00, reg_write=1.
- BEQ: a=10, b=00, alu_op=01, result_src=00, pc_write=zero.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1.
- JALR_PC: a=10, b=01, alu_op=00, result_src=10, pc_write=1.
- JALR_LINK: a=01, b=10, alu_op=00.
REQ-010 SHALL decode imm_src combinationally from opcode in every state: 0100011 gives 01, 1100011 gives 10, 1101111 gives 11, all other opcodes give 00.
REQ-011 SHALL sequence the FSM as follows:
- IDLE always goes to FETCH.
- FETCH goes to DECODE on mem_ready.
- From DECODE: 0000011 and 0100011 go to MEMADR; 0110011 goes to EXECR; 0010011 goes to EXECI; 1100011 goes to BEQ; 1101111 goes to JAL; 1100111 goes to JALR_PC; any other opcode goes to FAULT.
REQ-012 SHALL sequence the remaining states as follows:
- MEMADR goes to MEMREAD for a load and to MEMWRITE for a store.
- MEMREAD goes to MEMWB on mem_ready.
- MEMWRITE goes to FETCH on mem_ready.
- EXECR, EXECI and JAL go to ALUWB.
- JALR_PC goes to JALR_LINK, and JALR_LINK goes to ALUWB.
- MEMWB, ALUWB, BEQ and FAULT go to FETCH.
REQ-013 SHALL hold FETCH, MEMREAD and MEMWRITE, with outputs stable, while mem_ready=0.
REQ-014 SHALL clear an 8-bit wait counter on entry to FETCH, MEMREAD or MEMWRITE, and increment it on each cycle in those states with mem_ready=0.
REQ-015 SHALL go to FAULT with mem_timeout=1 for that cycle when mem_ready=0 and the counter equals TIMEOUT_CYC-1; mem_ready=1 in that same cycle SHALL take priority and complete normally.
REQ-016 SHALL pulse illegal_instr=1 in the DECODE cycle that goes to FAULT; because PC already advanced in FETCH, the illegal instruction is skipped.
REQ-017 SHALL produce a CPI of: 3 for BEQ, 4 for R-type, I-type and JAL, 4 for a store, 5 for a load, and 5 for JALR, all with zero wait states.

Reset
REQ-018 SHALL, while rst_n=0, force state to IDLE and clear the wait counter asynchronously, including mid-instruction; all outputs other than imm_src SHALL be 0.
REQ-019 SHALL issue the first mem_req on the second rising clk edge after rst_n deasserts (IDLE, then FETCH).

Configuration
REQ-020 SHALL support the compile-time macro JALR_SUPPORT_EN, which selects JALR handling as follows:
- Defined: JALR_PC and JALR_LINK exist, and opcode 1100111 is legal.
- Undefined: both states are compiled out, and 1100111 takes the illegal-opcode path of REQ-016.

Verification
REQ-021 SHALL verify: rst_n low, then high, with mem_ready=1 and opcode=0110011 -> states IDLE, FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 exactly once; pc_write=1 exactly once.
REQ-022 SHALL verify: load (0000011) with mem_ready held low for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles, MEMWB follows with result_src=01 and reg_write=1.
REQ-023 SHALL verify: BEQ with zero=1 -> pc_write=1 in BEQ; BEQ with zero=0 -> pc_write=0 in BEQ; both return to FETCH after 3 cycles.
REQ-024 SHALL verify timeout with TIMEOUT_CYC=4:
- mem_ready=0 throughout FETCH -> mem_timeout=1 on the 4th wait cycle, FAULT, then FETCH.
- Repeat with mem_ready=1 on the 4th cycle -> DECODE and no mem_timeout.
REQ-025 SHALL verify: opcode=1111111 -> illegal_instr=1 in DECODE, then FAULT, then FETCH; with JALR_SUPPORT_EN undefined, opcode 1100111 -> same response.
REQ-026 SHALL verify: rst_n pulled low during MEMWRITE with mem_req=1 -> mem_req=0 and mem_write=0 immediately without a clock edge; the FSM restarts at IDLE.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM with memory wait/timeout handling.
// Define JALR_SUPPORT_EN at compile time to enable the JALR_PC/JALR_LINK path.
module multicycle_controller #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic       illegal_instr,
    output logic       mem_timeout
);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BEQ, JAL,
`ifdef JALR_SUPPORT_EN
        JALR_PC, JALR_LINK,
`endif
        FAULT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
`ifdef JALR_SUPPORT_EN
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT_CYC - 1);

    state_t     state_q, state_d, dec_state;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       start_q, start_d;
    logic       dec_illegal, in_wait, timeout_hit;

    logic       mem_req_q, mem_req_d, mem_write_q, mem_write_d;
    logic       adr_src_q, adr_src_d, reg_write_q, reg_write_d;
    logic       pc_write_q, pc_write_d;
    logic [1:0] alu_src_a_q, alu_src_a_d, alu_src_b_q, alu_src_b_d;
    logic [1:0] alu_op_q, alu_op_d, result_src_q, result_src_d;

    assign in_wait     = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    assign timeout_hit = in_wait && !mem_ready && (wait_cnt_q == TMO_LAST);

    always_comb begin
        dec_state   = FAULT;
        dec_illegal = 1'b1;
        case (opcode)
            OP_LOAD, OP_STORE: begin dec_state = MEMADR; dec_illegal = 1'b0; end
            OP_RTYPE:          begin dec_state = EXECR;  dec_illegal = 1'b0; end
            OP_ITYPE:          begin dec_state = EXECI;  dec_illegal = 1'b0; end
            OP_BRANCH:         begin dec_state = BEQ;    dec_illegal = 1'b0; end
            OP_JAL:            begin dec_state = JAL;    dec_illegal = 1'b0; end
`ifdef JALR_SUPPORT_EN
            OP_JALR:           begin dec_state = JALR_PC; dec_illegal = 1'b0; end
`endif
            default: ;
        endcase
    end

    // start_q keeps IDLE for one full edge after reset release.
    always_comb begin
        state_d = state_q;
        start_d = 1'b1;
        case (state_q)
            IDLE:      if (start_q) state_d = FETCH;
            FETCH:     if (mem_ready) state_d = DECODE;
                       else if (timeout_hit) state_d = FAULT;
            DECODE:    state_d = dec_state;
            MEMADR:    state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:   if (mem_ready) state_d = MEMWB;
                       else if (timeout_hit) state_d = FAULT;
            MEMWRITE:  if (mem_ready) state_d = FETCH;
                       else if (timeout_hit) state_d = FAULT;
            EXECR, EXECI, JAL: state_d = ALUWB;
`ifdef JALR_SUPPORT_EN
            JALR_PC:   state_d = JALR_LINK;
            JALR_LINK: state_d = ALUWB;
`endif
            default:   state_d = FETCH;
        endcase
        wait_cnt_d = (in_wait && !mem_ready && !timeout_hit) ? wait_cnt_q + 8'd1 : 8'd0;
    end

    // Moore outputs are decoded from the next state so they appear registered.
    always_comb begin
        mem_req_d    = 1'b0;
        mem_write_d  = 1'b0;
        adr_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        pc_write_d   = 1'b0;
        alu_src_a_d  = 2'b00;
        alu_src_b_d  = 2'b00;
        alu_op_d     = 2'b00;
        result_src_d = 2'b00;
        case (state_d)
            FETCH:     begin mem_req_d = 1'b1; alu_src_b_d = 2'b10; result_src_d = 2'b10; end
            DECODE:    begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b01; end
            MEMADR:    begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; end
            MEMREAD:   begin mem_req_d = 1'b1; adr_src_d = 1'b1; end
            MEMWRITE:  begin mem_req_d = 1'b1; mem_write_d = 1'b1; adr_src_d = 1'b1; end
            MEMWB:     begin result_src_d = 2'b01; reg_write_d = 1'b1; end
            EXECR:     begin alu_src_a_d = 2'b10; alu_op_d = 2'b10; end
            EXECI:     begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; alu_op_d = 2'b10; end
            ALUWB:     reg_write_d = 1'b1;
            BEQ:       begin alu_src_a_d = 2'b10; alu_op_d = 2'b01; end
            JAL:       begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b10; pc_write_d = 1'b1; end
`ifdef JALR_SUPPORT_EN
            JALR_PC:   begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; result_src_d = 2'b10;
                             pc_write_d = 1'b1; end
            JALR_LINK: begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b10; end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_cnt_q   <= 8'd0;
            start_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            adr_src_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            pc_write_q   <= 1'b0;
            alu_src_a_q  <= 2'b00;
            alu_src_b_q  <= 2'b00;
            alu_op_q     <= 2'b00;
            result_src_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            start_q      <= start_d;
            mem_req_q    <= mem_req_d;
            mem_write_q  <= mem_write_d;
            adr_src_q    <= adr_src_d;
            reg_write_q  <= reg_write_d;
            pc_write_q   <= pc_write_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            alu_op_q     <= alu_op_d;
            result_src_q <= result_src_d;
        end
    end

    // Handshake-dependent strobes stay combinational on the current state.
    assign ir_write      = (state_q == FETCH) && mem_ready;
    assign pc_write      = pc_write_q || ir_write || ((state_q == BEQ) && zero);
    assign illegal_instr = (state_q == DECODE) && dec_illegal;
    assign mem_timeout   = timeout_hit;

    assign mem_req    = mem_req_q;
    assign mem_write  = mem_write_q;
    assign adr_src    = adr_src_q;
    assign reg_write  = reg_write_q;
    assign alu_src_a  = alu_src_a_q;
    assign alu_src_b  = alu_src_b_q;
    assign alu_op     = alu_op_q;
    assign result_src = result_src_q;

    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = 2'b01;
            OP_BRANCH: imm_src = 2'b10;
            OP_JAL:    imm_src = 2'b11;
            default:   imm_src = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: instruction-level reference model
// pushes per-cycle expected outputs; a negedge monitor pops and compares.
module tb_multicycle_controller;

    localparam int T = 4;

    localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMREAD = 4;
    localparam int P_MEMWB = 5, P_MEMWRITE = 6, P_EXECR = 7, P_EXECI = 8, P_ALUWB = 9;
    localparam int P_BEQ = 10, P_JAL = 11, P_JALR_PC = 12, P_JALR_LINK = 13, P_FAULT = 14;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, imm_src;
    logic       illegal_instr, mem_timeout;

    logic [17:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [17:0] act;

    always #5 clk = ~clk;

    multicycle_controller #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src), .imm_src(imm_src),
        .illegal_instr(illegal_instr), .mem_timeout(mem_timeout)
    );

    assign act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, result_src, imm_src, illegal_instr, mem_timeout};

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return 2'b01;
            OP_BRANCH: return 2'b10;
            OP_JAL:    return 2'b11;
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: return 1'b1;
`ifdef JALR_SUPPORT_EN
            OP_JALR: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic string ph_name(input int ph);
        case (ph)
            P_IDLE: return "idle";         P_FETCH: return "fetch";
            P_DECODE: return "decode";     P_MEMADR: return "memadr";
            P_MEMREAD: return "memread";   P_MEMWB: return "memwb";
            P_MEMWRITE: return "memwrite"; P_EXECR: return "execr";
            P_EXECI: return "execi";       P_ALUWB: return "aluwb";
            P_BEQ: return "beq";           P_JAL: return "jal";
            P_JALR_PC: return "jalr_pc";   P_JALR_LINK: return "jalr_link";
            default: return "fault";
        endcase
    endfunction

    // Output table per phase, straight from the control-signal listing.
    function automatic logic [17:0] vec(input int ph, input logic [6:0] op, input logic rdy,
                                        input logic z, input logic tmo, input logic ill);
        logic mreq = 1'b0, mw = 1'b0, adr = 1'b0, irw = 1'b0, pcw = 1'b0, rw = 1'b0;
        logic [1:0] a = 2'b00, b = 2'b00, alu = 2'b00, res = 2'b00;
        case (ph)
            P_FETCH:     begin mreq = 1'b1; b = 2'b10; res = 2'b10; irw = rdy; pcw = rdy; end
            P_DECODE:    begin a = 2'b01; b = 2'b01; end
            P_MEMADR:    begin a = 2'b10; b = 2'b01; end
            P_MEMREAD:   begin mreq = 1'b1; adr = 1'b1; end
            P_MEMWRITE:  begin mreq = 1'b1; mw = 1'b1; adr = 1'b1; end
            P_MEMWB:     begin res = 2'b01; rw = 1'b1; end
            P_EXECR:     begin a = 2'b10; alu = 2'b10; end
            P_EXECI:     begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            P_ALUWB:     rw = 1'b1;
            P_BEQ:       begin a = 2'b10; alu = 2'b01; pcw = z; end
            P_JAL:       begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            P_JALR_PC:   begin a = 2'b10; b = 2'b01; res = 2'b10; pcw = 1'b1; end
            P_JALR_LINK: begin a = 2'b01; b = 2'b10; end
            default: ;
        endcase
        return {mreq, mw, adr, irw, pcw, rw, a, b, alu, res, imm_of(op), ill, tmo};
    endfunction

    task automatic step(input int ph, input logic [6:0] op, input logic z, input logic rdy,
                        input logic tmo, input logic ill);
        @(posedge clk);
        #1;
        opcode    = op;
        zero      = z;
        mem_ready = rdy;
        exp_q.push_back(vec(ph, op, rdy, z, tmo, ill));
        name_q.push_back(ph_name(ph));
    endtask

    // A memory phase: 'waits' cycles without ready, timing out on the T-th wait cycle.
    task automatic wait_phase(input int ph, input logic [6:0] op, input int waits,
                              output logic timed_out);
        logic done = 1'b0;
        timed_out = 1'b0;
        for (int k = 0; k < T; k++) begin
            if (!done) begin
                if (k >= waits) begin
                    step(ph, op, rb(), 1'b1, 1'b0, 1'b0);
                    done = 1'b1;
                end else if (k == T - 1) begin
                    step(ph, op, rb(), 1'b0, 1'b1, 1'b0);
                    timed_out = 1'b1;
                    done = 1'b1;
                end else begin
                    step(ph, op, rb(), 1'b0, 1'b0, 1'b0);
                end
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
        logic to;
        wait_phase(P_FETCH, op, fw, to);
        if (to) begin
            step(P_FAULT, op, rb(), rb(), 1'b0, 1'b0);
            return;
        end
        if (!legal(op)) begin
            step(P_DECODE, op, rb(), rb(), 1'b0, 1'b1);
            step(P_FAULT, op, rb(), rb(), 1'b0, 1'b0);
            return;
        end
        step(P_DECODE, op, rb(), rb(), 1'b0, 1'b0);
        case (op)
            OP_LOAD, OP_STORE: begin
                step(P_MEMADR, op, rb(), rb(), 1'b0, 1'b0);
                wait_phase((op == OP_LOAD) ? P_MEMREAD : P_MEMWRITE, op, mw, to);
                if (to) step(P_FAULT, op, rb(), rb(), 1'b0, 1'b0);
                else if (op == OP_LOAD) step(P_MEMWB, op, rb(), rb(), 1'b0, 1'b0);
            end
            OP_RTYPE, OP_ITYPE: begin
                step((op == OP_RTYPE) ? P_EXECR : P_EXECI, op, rb(), rb(), 1'b0, 1'b0);
                step(P_ALUWB, op, rb(), rb(), 1'b0, 1'b0);
            end
            OP_BRANCH: step(P_BEQ, op, z, rb(), 1'b0, 1'b0);
            OP_JAL: begin
                step(P_JAL, op, rb(), rb(), 1'b0, 1'b0);
                step(P_ALUWB, op, rb(), rb(), 1'b0, 1'b0);
            end
            default: begin
                step(P_JALR_PC, op, rb(), rb(), 1'b0, 1'b0);
                step(P_JALR_LINK, op, rb(), rb(), 1'b0, 1'b0);
                step(P_ALUWB, op, rb(), rb(), 1'b0, 1'b0);
            end
        endcase
    endtask

    // IDLE before the first edge after release and for one more edge, then FETCH.
    task automatic release_reset(input logic [6:0] op);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        opcode = op;
        exp_q.push_back(vec(P_IDLE, op, 1'b0, 1'b0, 1'b0, 1'b0));
        name_q.push_back("release");
        step(P_IDLE, op, rb(), rb(), 1'b0, 1'b0);
    endtask

    task automatic reset_in_memwrite();
        logic to;
        wait_phase(P_FETCH, OP_STORE, 0, to);
        step(P_DECODE, OP_STORE, rb(), rb(), 1'b0, 1'b0);
        step(P_MEMADR, OP_STORE, rb(), rb(), 1'b0, 1'b0);
        step(P_MEMWRITE, OP_STORE, rb(), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_mem mem_req=%b mem_write=%b required=0 0", mem_req, mem_write);
        end
        checks++;
        if ((act & 18'h3fff3) !== 18'h0) begin
            errors++;
            $display("FAIL async_reset_all got=%b required=zero except imm_src", act);
        end
        for (int i = 0; i < 2; i++) step(P_IDLE, OP_STORE, rb(), rb(), 1'b0, 1'b0);
        release_reset(OP_RTYPE);
    endtask

    initial begin : monitor
        logic [17:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s t=%0t got=%b required=%b", nm, $time, act, e);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [6:0] ops[9];
        ops[0] = OP_LOAD;  ops[1] = OP_STORE; ops[2] = OP_RTYPE;
        ops[3] = OP_ITYPE; ops[4] = OP_BRANCH; ops[5] = OP_JAL;
        ops[6] = OP_JALR;  ops[7] = OP_BAD;   ops[8] = OP_RTYPE;

        for (int i = 0; i < 3; i++) step(P_IDLE, OP_RTYPE, rb(), 1'b1, 1'b0, 1'b0);
        release_reset(OP_RTYPE);

        run_instr(OP_RTYPE, 1'b0, 0, 0);
        run_instr(OP_LOAD, 1'b0, 0, 3);
        run_instr(OP_BRANCH, 1'b1, 0, 0);
        run_instr(OP_BRANCH, 1'b0, 0, 0);
        run_instr(OP_RTYPE, 1'b0, 9, 0);
        run_instr(OP_ITYPE, 1'b0, 3, 0);
        run_instr(OP_BAD, 1'b0, 0, 0);
        run_instr(OP_JALR, 1'b0, 0, 0);
        run_instr(OP_STORE, 1'b0, 0, 1);
        run_instr(OP_JAL, 1'b0, 0, 0);
        run_instr(OP_LOAD, 1'b0, 1, 7);
        run_instr(OP_STORE, 1'b0, 0, 6);
        reset_in_memwrite();

        for (int n = 0; n < 250; n++) begin
            logic [6:0] op;
            int fw, mw;
            op = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 9) == 0) op = 7'($urandom_range(0, 127));
            fw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, 6);
            mw = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(0, 6);
            run_instr(op, rb(), fw, mw);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
